// File: rtl/bin_to_bcd_six_pkg.sv
// Shared constants for the six-digit binary-to-BCD converter.
// The display side and the converter both rely on these widths and limits.
package bin_to_bcd_six_pkg;

  // Number of decimal digits presented to the display controller
  localparam int BCD_DIGITS = 6;

  // Packed width of the BCD result, four bits per digit
  localparam int BCD_WIDTH = 4 * BCD_DIGITS;

  // Largest value that still fits in six decimal digits
  localparam logic [19:0] BCD_MAX = 20'd999999;

  // Pattern shown on the display when the input is out of range
  localparam logic [23:0] BCD_SATURATE = 24'h999999;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit.
// A digit of 5 or more would carry past 9 after the next doubling, so it is
// pre-biased by 3 here. The arithmetic stays 4 bits wide; the largest legal
// input (9) becomes 12, which still fits.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Add 3 to digits that would overflow a decimal position when doubled
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_six.sv
// Sequential binary-to-BCD converter for the six-digit display.
// One input bit is consumed per clock using shift-and-add-3 (double-dabble).
// Timing, with t0 being the rising edge that samples Start in IDLE:
//   - edges t0+1 .. t0+20 each perform one shift,
//   - the shift at t0+20 also loads Bcd/Overflow and moves the FSM to DONE,
//   - Done is therefore the value seen at edge t0+21 (21 edges after t0),
//   - the FSM is back in IDLE for edge t0+22, so a held Start repeats every
//     22 clocks.
// Bcd/Overflow are only written at the end of a conversion, so the display
// keeps showing the previous result while a new one is being computed.
// Reset is asynchronous and active low; release synchronisation lives at
// the top level of the system.
module bin_to_bcd_six
  import bin_to_bcd_six_pkg::*;
#(
  parameter int BIN_WIDTH = 20
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [BIN_WIDTH-1:0] Binary,
  output logic                 Busy,
  output logic                 Done,
  output logic [BCD_WIDTH-1:0] Bcd,
  output logic                 Overflow
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // The counter starts at BIN_WIDTH-1 and the last shift happens when it reads 0
  localparam logic [4:0] COUNT_LOAD = 5'(BIN_WIDTH - 1);

  state_e                 state_q,      state_d;
  logic [BIN_WIDTH-1:0]   shiftReg_q,   shiftReg_d;
  logic [BCD_WIDTH-1:0]   accum_q,      accum_d;
  logic [4:0]             count_q,      count_d;
  logic                   ovfPending_q, ovfPending_d;
  logic [BCD_WIDTH-1:0]   bcd_q,        bcd_d;
  logic                   overflow_q,   overflow_d;

  logic [BCD_WIDTH-1:0]           adjusted;
  logic [BCD_WIDTH+BIN_WIDTH-1:0] shifted;

  // One add-3 corrector per digit of the accumulator
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : gen_adjust
    bcd_digit_adjust u_adjust (
      .digit_i(accum_q[4*g +: 4]),
      .digit_o(adjusted[4*g +: 4])
    );
  end

  // Corrected accumulator and remaining binary bits move left together
  assign shifted = {adjusted, shiftReg_q} << 1;

  // Register all state; reset clears everything, including the visible result
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      shiftReg_q   <= '0;
      accum_q      <= '0;
      count_q      <= '0;
      ovfPending_q <= 1'b0;
      bcd_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shiftReg_q   <= shiftReg_d;
      accum_q      <= accum_d;
      count_q      <= count_d;
      ovfPending_q <= ovfPending_d;
      bcd_q        <= bcd_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state and datapath control; Start is only looked at in IDLE
  always_comb begin
    state_d      = state_q;
    shiftReg_d   = shiftReg_q;
    accum_d      = accum_q;
    count_d      = count_q;
    ovfPending_d = ovfPending_q;
    bcd_d        = bcd_q;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          shiftReg_d   = Binary;
          accum_d      = '0;
          count_d      = COUNT_LOAD;
          ovfPending_d = (Binary > BCD_MAX);
          state_d      = SHIFT;
        end
      end

      SHIFT: begin
        shiftReg_d = shifted[BIN_WIDTH-1:0];
        accum_d    = shifted[BCD_WIDTH+BIN_WIDTH-1:BIN_WIDTH];
        if (count_q == 5'd0) begin
          bcd_d      = ovfPending_q ? BCD_SATURATE
                                    : shifted[BCD_WIDTH+BIN_WIDTH-1:BIN_WIDTH];
          overflow_d = ovfPending_q;
          state_d    = DONE;
        end else begin
          count_d = count_q - 5'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);
  assign Bcd      = bcd_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_six.sv
// Directed bench for bin_to_bcd_six with hand-computed BCD results.
// Outputs are sampled at the falling edge, i.e. the value that the next
// rising edge will see; "edge t0+k" below means the k-th rising edge after
// the one that sampled Start.
module tb_bin_to_bcd_six;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [19:0] Binary;
  logic        Busy;
  logic        Done;
  logic [23:0] Bcd;
  logic        Overflow;

  int checks   = 0;
  int failures = 0;

  logic [23:0] lastBcd;
  logic        lastOvf;

  int doneCount;
  int doneEdge;
  int spurious;
  int doneAt [3];

  bin_to_bcd_six #(.BIN_WIDTH(20)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .Binary  (Binary),
    .Busy    (Busy),
    .Done    (Done),
    .Bcd     (Bcd),
    .Overflow(Overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse Start for one rising edge (t0); Binary is scrambled afterwards
  // because it must not matter outside the sampling edge
  task automatic applyStimulus(input logic [19:0] value);
    @(negedge Clock);
    Binary = value;
    Start  = 1'b1;
    @(posedge Clock);
    #1;
    Start  = 1'b0;
    Binary = 20'($urandom);
    checkOutput("hold_bcd", 32'(Bcd), 32'(lastBcd));
    checkOutput("hold_ovf", 32'(Overflow), 32'(lastOvf));
  endtask

  // Wait for Done, reporting which edge after t0 sees it and how many
  // sampled cycles had Busy high
  task automatic waitDone(output int latency, output int busyCycles);
    latency    = 0;
    busyCycles = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clock);
      if (Busy) busyCycles++;
      if (Done) begin
        latency = n;
        break;
      end
      @(posedge Clock);
    end
    if (latency == 0) checkOutput("done_timeout", 32'd0, 32'd21);
  endtask

  task automatic convertAndCheck(input string tag, input logic [19:0] value,
                                 input logic [23:0] expBcd, input logic expOvf);
    int latency;
    int busyCycles;
    applyStimulus(value);
    waitDone(latency, busyCycles);
    checkOutput({tag, "_latency"}, 32'(latency), 32'd21);
    checkOutput({tag, "_busy"}, 32'(busyCycles), 32'd21);
    checkOutput({tag, "_bcd"}, 32'(Bcd), 32'(expBcd));
    checkOutput({tag, "_ovf"}, 32'(Overflow), 32'(expOvf));
    @(posedge Clock);
    @(negedge Clock);
    checkOutput({tag, "_done_pulse"}, 32'(Done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(Busy), 32'd0);
    lastBcd = expBcd;
    lastOvf = expOvf;
  endtask

  initial begin
    Reset   = 1'b1;
    Start   = 1'b0;
    Binary  = '0;
    lastBcd = '0;
    lastOvf = 1'b0;

    // Asynchronous reset, checked before any clock edge
    #2 Reset = 1'b0;
    #1;
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_done", 32'(Done), 32'd0);
    checkOutput("reset_bcd", 32'(Bcd), 32'd0);
    checkOutput("reset_ovf", 32'(Overflow), 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;

    // Plain conversions and the range boundaries
    convertAndCheck("zero", 20'd0, 24'h000000, 1'b0);
    convertAndCheck("mid", 20'h1E240, 24'h123456, 1'b0);
    convertAndCheck("max_fit", 20'd999999, 24'h999999, 1'b0);
    convertAndCheck("first_ovf", 20'd1000000, 24'h999999, 1'b1);
    convertAndCheck("small", 20'd7, 24'h000007, 1'b0);
    convertAndCheck("ten", 20'd10, 24'h000010, 1'b0);

    // Start while busy is ignored (t0+5 and t0+21), accepted at t0+22
    applyStimulus(20'd42);
    doneCount = 0;
    doneEdge  = 0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge Clock);
      if (Done) begin
        doneCount++;
        doneEdge = k;
      end
      if (k == 21) checkOutput("ignore_bcd", 32'(Bcd), 32'h000042);
      Start  = (k == 5) || (k == 21);
      Binary = ((k == 5) || (k == 21)) ? 20'd77 : 20'($urandom);
      @(posedge Clock);
    end
    checkOutput("ignore_done_count", 32'(doneCount), 32'd1);
    checkOutput("ignore_done_edge", 32'(doneEdge), 32'd21);
    lastBcd = 24'h000042;
    lastOvf = 1'b0;
    convertAndCheck("accept_t22", 20'd77, 24'h000077, 1'b0);

    // Reset in the middle of a conversion aborts it without a Done
    applyStimulus(20'd555555);
    repeat (10) @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(Busy), 32'd0);
    checkOutput("abort_done", 32'(Done), 32'd0);
    checkOutput("abort_bcd", 32'(Bcd), 32'd0);
    checkOutput("abort_ovf", 32'(Overflow), 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    spurious = 0;
    repeat (30) begin
      @(negedge Clock);
      if (Done) spurious++;
    end
    checkOutput("abort_no_done", 32'(spurious), 32'd0);
    lastBcd = '0;
    lastOvf = 1'b0;
    convertAndCheck("after_reset", 20'd654321, 24'h654321, 1'b0);

    // Start held high: a saturated result every 22 clocks
    @(negedge Clock);
    Binary = 20'd1048575;
    Start  = 1'b1;
    @(posedge Clock);
    doneCount = 0;
    for (int i = 0; i < 3; i++) doneAt[i] = 0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge Clock);
      if (Done) begin
        if (doneCount < 3) doneAt[doneCount] = k;
        doneCount++;
        checkOutput("held_bcd", 32'(Bcd), 32'h999999);
        checkOutput("held_ovf", 32'(Overflow), 32'd1);
      end
      if (k == 66) Start = 1'b0;
      @(posedge Clock);
    end
    checkOutput("held_count", 32'(doneCount), 32'd3);
    checkOutput("held_first", 32'(doneAt[0]), 32'd21);
    checkOutput("held_gap1", 32'(doneAt[1] - doneAt[0]), 32'd22);
    checkOutput("held_gap2", 32'(doneAt[2] - doneAt[1]), 32'd22);
    @(negedge Clock);
    checkOutput("held_idle", 32'(Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
